// File: rtl/arb_pkg.sv
// Shared constants and types for the arbiter dispatch path and its per-core receive queues.
package arb_pkg;

    localparam int INSTR_W       = 32;
    localparam int DEFAULT_DEPTH = 8;
    localparam int STAT_W        = 16;

    // Instruction field layout as produced by the arbiter.
    localparam int FORCE_BIT     = 27;
    localparam int CORE_SEL_BIT  = 26;
    localparam int SRC_FLAG_BIT  = 23;
    localparam int DST_FLAG_BIT  = 22;
    localparam int DST_MSB       = 21;
    localparam int DST_LSB       = 11;
    localparam int SRC_MSB       = 10;
    localparam int SRC_LSB       = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fifo_state_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value, input logic en);
        return (en && (value != {STAT_W{1'b1}})) ? value + STAT_W'(1) : value;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH instruction storage: synchronous write, asynchronous read.
module fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is not reset; occupancy is tracked by count, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/core_instr_fifo.sv
// Per-core instruction receive queue: drops bubbles, issues the head over valid/ready, single-cycle flush.
// Define FIFO_STATS_EN to add saturating pushed/bubble/hold-cycle statistics outputs.
module core_instr_fifo #(
    parameter int DEPTH   = arb_pkg::DEFAULT_DEPTH,
    parameter int INSTR_W = arb_pkg::INSTR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [INSTR_W-1:0]         push_data,
    output logic                       push_ready,
    output logic                       issue_valid,
    output logic [INSTR_W-1:0]         issue_instr,
    input  logic                       issue_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
`ifdef FIFO_STATS_EN
    ,
    output logic [arb_pkg::STAT_W-1:0] stat_pushed,
    output logic [arb_pkg::STAT_W-1:0] stat_bubbles,
    output logic [arb_pkg::STAT_W-1:0] stat_hold_cycles
`endif
);

    import arb_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      rd_ptr_nxt;
    logic [CW-1:0]      count_nxt;
    logic [INSTR_W-1:0] ram_rdata;
    logic [INSTR_W-1:0] instr_nxt;
    logic               push_acc;
    logic               store;
    logic               pop;
    logic               bypass;
    fifo_state_e        state;
    fifo_state_e        state_nxt;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign push_ready  = !full;
    assign issue_valid = (state == ISSUE) || (state == HOLD);

    // Flush outranks both sides of the handshake in the same cycle.
    assign push_acc   = push_valid && push_ready && !flush;
    assign store      = push_acc && (push_data != '0);
    assign pop        = issue_valid && issue_ready && !flush;

    // The word being written becomes the new head only when the queue drains to it this cycle.
    assign bypass     = store && (count == CW'(pop));
    assign rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign count_nxt  = count + CW'(store) - CW'(pop);
    assign instr_nxt  = bypass ? push_data : ram_rdata;

    fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (push_data),
        .raddr (rd_ptr_nxt),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            issue_instr <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            issue_instr <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            // Reloading from the unchanged head while held keeps issue_instr stable.
            if (count_nxt != '0) begin
                issue_instr <= instr_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is defaulted before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (count_nxt != '0) state_nxt = ISSUE;
            end
            ISSUE, HOLD: begin
                if (!issue_ready)          state_nxt = HOLD;
                else if (count_nxt == '0)  state_nxt = IDLE;
                else                       state_nxt = ISSUE;
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = FLUSH;
    end

`ifdef FIFO_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pushed      <= '0;
            stat_bubbles     <= '0;
            stat_hold_cycles <= '0;
        end else if (flush) begin
            stat_pushed      <= '0;
            stat_bubbles     <= '0;
            stat_hold_cycles <= '0;
        end else begin
            stat_pushed      <= sat_inc(stat_pushed, store);
            stat_bubbles     <= sat_inc(stat_bubbles, push_acc && !store);
            stat_hold_cycles <= sat_inc(stat_hold_cycles, state == HOLD);
        end
    end
`endif

endmodule

// File: tb/tb_core_instr_fifo.sv
// Scoreboard bench for core_instr_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_core_instr_fifo;

    localparam int DEPTH   = 8;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               push_valid;
    logic [INSTR_W-1:0] push_data;
    logic               push_ready;
    logic               issue_valid;
    logic [INSTR_W-1:0] issue_instr;
    logic               issue_ready;
    logic               flush;
    logic [3:0]         count;
    logic               full;
    logic               empty;
`ifdef FIFO_STATS_EN
    logic [15:0]        stat_pushed;
    logic [15:0]        stat_bubbles;
    logic [15:0]        stat_hold_cycles;
`endif

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [INSTR_W-1:0] exp_q[$];
    int                 model_count = 0;

    always #5 clk = ~clk;

    core_instr_fifo #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_ready (issue_ready),
        .flush       (flush),
        .count       (count),
        .full        (full),
        .empty       (empty)
`ifdef FIFO_STATS_EN
        ,
        .stat_pushed      (stat_pushed),
        .stat_bubbles     (stat_bubbles),
        .stat_hold_cycles (stat_hold_cycles)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic step(input logic pv, input logic [31:0] pd, input logic ir, input logic fl);
        push_valid  = pv;
        push_data   = pd;
        issue_ready = ir;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever an instruction is presented it must be the oldest outstanding one.
    always @(negedge clk) begin
        if (!rst && issue_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_unexpected: got %h expected nothing presented at %0t", issue_instr, $time);
            end else begin
                check("issue_instr", issue_instr, exp_q[0]);
                if (issue_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    // Reference model: occupancy of a bounded queue that drops zero words and empties on flush.
    always @(negedge clk) begin
        bit do_pop;
        bit do_store;
        #1;
        if (rst) begin
            model_count = 0;
            exp_q.delete();
        end else begin
            check("count",       32'(count),       32'(model_count));
            check("issue_valid", 32'(issue_valid), 32'(model_count != 0));
            check("full",        32'(full),        32'(model_count == DEPTH));
            check("empty",       32'(empty),       32'(model_count == 0));
            check("push_ready",  32'(push_ready),  32'(model_count < DEPTH));
            if (flush) begin
                model_count = 0;
                exp_q.delete();
            end else begin
                do_pop   = issue_ready && (model_count > 0);
                do_store = push_valid && (model_count < DEPTH) && (push_data != 0);
                if (do_store) begin
                    exp_q.push_back(push_data);
                    model_count++;
                end
                if (do_pop) model_count--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic        last_fl;
        logic        fl;
        logic [31:0] d;
        int          w;

        rst = 1'b1;
        push_valid = 1'b0;
        push_data = '0;
        issue_ready = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_issue_instr", issue_instr, 32'd0);
        check("rst_push_ready",  32'(push_ready),  32'd1);
        check("rst_full",        32'(full),        32'd0);
        check("rst_empty",       32'(empty),       32'd1);
        check("rst_count",       32'(count),       32'd0);
        rst = 1'b0;

        // In-order issue with one cycle of latency.
        step(1'b1, 32'h0800_0001, 1'b1, 1'b0);
        check("lat_valid", 32'(issue_valid), 32'd1);
        check("lat_instr", issue_instr, 32'h0800_0001);
        step(1'b1, 32'h0000_0802, 1'b1, 1'b0);
        check("b2b_instr2", issue_instr, 32'h0000_0802);
        step(1'b1, 32'h0000_1003, 1'b1, 1'b0);
        check("b2b_instr3", issue_instr, 32'h0000_1003);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("drain_count", 32'(count), 32'd0);
        check("drain_valid", 32'(issue_valid), 32'd0);

        // Bubbles are accepted but never stored.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0, 1'b1, 1'b0);
            check("bubble_count", 32'(count), 32'd0);
        end
        step(1'b1, 32'h0000_00AA, 1'b1, 1'b0);
        check("bubble_aa_count", 32'(count), 32'd1);
        check("bubble_aa_instr", issue_instr, 32'h0000_00AA);
`ifdef FIFO_STATS_EN
        check("stat_bubbles", 32'(stat_bubbles), 32'd3);
        check("stat_pushed",  32'(stat_pushed),  32'd1);
`endif
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill while the core stalls; the ninth push is refused.
        for (int i = 0; i < 9; i++) step(1'b1, 32'hA000_0001 + 32'(i), 1'b0, 1'b0);
        check("fill_full",       32'(full),       32'd1);
        check("fill_push_ready", 32'(push_ready), 32'd0);
        check("fill_count",      32'(count),      32'd8);
        check("fill_head",       issue_instr,     32'hA000_0001);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("hold_head", issue_instr, 32'hA000_0001);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("fill_drained", 32'(empty), 32'd1);

        // Full queue streaming with a pop every cycle; pointers wrap several times.
        for (int i = 0; i < 8; i++) step(1'b1, 32'hB000_0001 + 32'(i), 1'b0, 1'b0);
        w = 1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 32'hC000_0000 + 32'(w), 1'b1, 1'b0);
            w++;
        end
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream_drained", 32'(empty), 32'd1);

        // Flush with a simultaneous push drops everything, including the pushed word.
        for (int i = 0; i < 5; i++) step(1'b1, 32'hD000_0001 + 32'(i), 1'b0, 1'b0);
        check("preflush_count", 32'(count), 32'd5);
        step(1'b1, 32'h0000_0555, 1'b1, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(issue_valid), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("postflush_valid", 32'(issue_valid), 32'd0);
        step(1'b1, 32'h0000_0777, 1'b1, 1'b0);
        check("postflush_instr", issue_instr, 32'h0000_0777);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while holding four entries.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hE000_0001 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("prerst_count", 32'(count), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(issue_valid), 32'd0);
        check("arst_count", 32'(count),       32'd0);
        check("arst_full",  32'(full),        32'd0);
        check("arst_empty", 32'(empty),       32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 32'h0000_F00D, 1'b1, 1'b0);
        check("resume_valid", 32'(issue_valid), 32'd1);
        check("resume_instr", issue_instr, 32'h0000_F00D);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic; no push is offered in the cycle right after a flush.
        last_fl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            fl = !last_fl && ($urandom_range(0, 99) < 3);
            d  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            step(!last_fl && ($urandom_range(0, 9) < 7), d, $urandom_range(0, 9) < 6, fl);
            last_fl = fl;
        end
        push_valid = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("final_empty", 32'(empty), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_instr_fifo.md
Name: core_instr_fifo

Overview:
- Per-core receive end of the arbiter dispatch path: sits between the arbiter's FIFO_1/FIFO_2 output and one pipelined core's fetch/issue stage.
- Buffers routed instructions in an 8-deep circular queue.
- Discards bubble words (all-zero).
- Presents one instruction at a time to the core over a valid/ready handshake.
- Supports a single-cycle flush for pipeline redirect.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 2.
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- push_valid  input  1  arbiter offers push_data this cycle.
- push_data  input  INSTR_W  instruction routed to this core.
- push_ready  output  1  queue can accept; equals !full.
- issue_valid  output  1  issue_instr is valid.
- issue_instr  output  INSTR_W  head instruction, registered.
- issue_ready  input  1  core accepts issue_instr this cycle.
- flush  input  1  discard all queued and presented instructions.
- count  output  $clog2(DEPTH)+1  number of stored entries, including the presented head.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (asynchronous, rst=1):
  - pointers=0, count=0, state=IDLE.
  - issue_valid=0, issue_instr=0, push_ready=1, full=0, empty=1.
- Push:
  - Accepted when push_valid && push_ready.
  - If push_data == 0 (bubble) it is accepted but not stored, and count is unchanged.
  - Otherwise it is written at wr_ptr; wr_ptr advances modulo DEPTH.
- Pop:
  - Occurs when issue_valid && issue_ready; rd_ptr advances modulo DEPTH.
- Simultaneous push and pop:
  - When not full, both occur and count is unchanged.
  - When full, push_ready=0, so only the pop occurs; push_ready rises the next cycle.
  - No same-cycle pass-through.
- Latency:
  - A non-bubble word pushed into an empty queue appears on issue_valid/issue_instr on the next clock edge (1 cycle).
  - Back-to-back pops sustain one instruction per cycle.
- issue_instr is a registered copy of the head entry. It is stable while issue_valid && !issue_ready.
- State machine:
  - IDLE: issue_valid=0. Go to ISSUE when count becomes non-zero.
  - ISSUE: issue_valid=1.
    - issue_ready=0 -> HOLD.
    - issue_ready=1 and this is the last entry with no push -> IDLE.
    - issue_ready=1 otherwise -> stay in ISSUE with the next head.
  - HOLD: issue_valid=1, outputs frozen. Go to ISSUE when issue_ready=1 (same pop rules as ISSUE).
  - FLUSH: entered from any state when flush=1.
    - Pointers and count clear at the edge.
    - issue_valid=0 for exactly one cycle, then IDLE.
- Flush priority:
  - Flush outranks push and pop in the same cycle; the pushed word is dropped.
  - push_ready stays high during a flush.
- Wrap-around: pointers are $clog2(DEPTH) bits. full/empty are derived from count, never from pointer equality.
- Reset mid-operation: all state is abandoned immediately and asynchronously.

Optional Feature:
- Macro FIFO_STATS_EN.
- When defined, adds three outputs, all cleared by reset and by flush:
  - stat_pushed (16-bit, saturating): non-bubble words stored.
  - stat_bubbles (16-bit, saturating): bubble words dropped.
  - stat_hold_cycles (16-bit, saturating): cycles spent in HOLD.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package arb_pkg holds:
  - INSTR_W.
  - DEFAULT_DEPTH=8.
  - Instruction field constants: FORCE_BIT=27, CORE_SEL_BIT=26, SRC_FLAG_BIT=23, DST_FLAG_BIT=22, DST_MSB=21, DST_LSB=11, SRC_MSB=10, SRC_LSB=0.
  - The state enum IDLE/ISSUE/HOLD/FLUSH.
- Sub-module fifo_ram (DEPTH x INSTR_W storage): synchronous write, asynchronous read by rd_ptr.
- core_instr_fifo owns the pointers, count, FSM and output register.

Test Plan:
- Reset, then push 32'h0800_0001, 32'h0000_0802, 32'h0000_1003 on consecutive cycles with issue_ready=1 -> issue_valid high from the cycle after the first push. Instructions are issued in order, one per cycle, and count returns to 0.
- Push 32'h0 three times, then 32'h0000_00AA -> count never exceeds 1; only 32'h0000_00AA is issued (with FIFO_STATS_EN: stat_bubbles=3, stat_pushed=1).
- Hold issue_ready=0 and push 8 non-zero words -> full=1, push_ready=0 and the 9th push is not accepted. issue_instr stays equal to the first word throughout. Then issue_ready=1 for 8 cycles drains all 8 words in order.
- Start full with issue_ready=1 and push_valid=1 every cycle -> one pop per cycle, push_ready high one cycle after each pop. Pointers wrap past index 7 with order preserved over 20 words.
- With count=5, assert flush together with push_valid (32'h0000_0555) -> next cycle count=0 and issue_valid=0 for one cycle; 32'h0000_0555 is never issued.
- Assert rst asynchronously mid-burst (count=4, state HOLD) -> issue_valid, count and full go to 0 and empty goes to 1 without waiting for a clock edge. Normal operation resumes after rst deasserts.
